// File: rtl/bus_cycle_controller.sv
// 68K bus cycle sequencer: paces DTACK for internally timed regions, forwards device
// DTACK for externally timed ones, and raises BERR on unmapped or stalled cycles.
module bus_cycle_controller #(
  parameter int ROM_WAIT    = 1,
  parameter int RAM_WAIT    = 1,
  parameter int IO_WAIT     = 3,
  parameter int OFFBRD_WAIT = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 11
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic OffBoardMemory_H,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic GraphicsCS_L,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  input  logic GraphicsDtack_L,
  input  logic ClearBerr_H,
  output logic Dtack_L,
  output logic BErr_L,
  output logic CycleActive_H,
  output logic BerrSticky_H
);

  typedef enum logic [2:0] {IDLE, COUNT, EXT, NOSEL, ACK, BERR} state_t;
  typedef enum logic [1:0] {SRC_DRAM, SRC_CAN, SRC_GFX} ack_src_t;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state;
  ack_src_t           ack_src;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   wd;
  logic [CNT_W-1:0]   wd_next;

  logic               start_internal;
  logic               start_external;
  logic [CNT_W-1:0]   start_wait;
  ack_src_t           start_src;
  logic               ext_ack;

  // Region decode in priority order; only consulted on the start edge.
  always_comb begin
    start_internal = 1'b1;
    start_external = 1'b0;
    start_wait     = '0;
    start_src      = SRC_DRAM;
    if (OnChipRomSelect_H) begin
      start_wait = CNT_W'(ROM_WAIT);
    end else if (OnChipRamSelect_H) begin
      start_wait = CNT_W'(RAM_WAIT);
    end else if (IOSelect_H) begin
      start_wait = CNT_W'(IO_WAIT);
    end else if (OffBoardMemory_H) begin
      start_wait = CNT_W'(OFFBRD_WAIT);
    end else begin
      start_internal = 1'b0;
      if (DramSelect_H) begin
        start_external = 1'b1;
        start_src      = SRC_DRAM;
      end else if (CanBusSelect_H) begin
        start_external = 1'b1;
        start_src      = SRC_CAN;
      end else if (!GraphicsCS_L) begin
        start_external = 1'b1;
        start_src      = SRC_GFX;
      end
    end
  end

  // Only the device latched at the start edge may acknowledge.
  always_comb begin
    ext_ack = 1'b0;
    case (ack_src)
      SRC_DRAM: ext_ack = !DramDtack_L;
      SRC_CAN:  ext_ack = !CanBusDtack_L;
      SRC_GFX:  ext_ack = !GraphicsDtack_L;
      default:  ext_ack = 1'b0;
    endcase
  end

  assign wd_next = (wd == CNT_MAX) ? wd : wd + CNT_W'(1);

  // NOTE: every state register here uses <= so all of them see the pre-edge
  // values; a later <= to the same register in this block overrides an earlier one.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state         <= IDLE;
      ack_src       <= SRC_DRAM;
      cnt           <= '0;
      wd            <= '0;
      Dtack_L       <= 1'b1;
      BErr_L        <= 1'b1;
      CycleActive_H <= 1'b0;
      BerrSticky_H  <= 1'b0;
    end else begin
      // Clear first so a BERR entry later in this block wins on the same edge.
      if (ClearBerr_H) BerrSticky_H <= 1'b0;

      case (state)
        IDLE: begin
          if (!AS_L) begin
            wd            <= '0;
            CycleActive_H <= 1'b1;
            if (start_internal) begin
              state <= COUNT;
              cnt   <= start_wait;
            end else if (start_external) begin
              state   <= EXT;
              ack_src <= start_src;
            end else begin
              state <= NOSEL;
            end
          end
        end

        COUNT: begin
          if (AS_L) begin
            state         <= IDLE;
            CycleActive_H <= 1'b0;
          end else begin
            wd <= wd_next;
            if (cnt == '0) begin
              state   <= ACK;
              Dtack_L <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        EXT: begin
          if (AS_L) begin
            state         <= IDLE;
            CycleActive_H <= 1'b0;
          end else begin
            wd <= wd_next;
            if (ext_ack) begin
              state   <= ACK;
              Dtack_L <= 1'b0;
            end else if (wd == WD_LIMIT) begin
              state        <= BERR;
              BErr_L       <= 1'b0;
              BerrSticky_H <= 1'b1;
            end
          end
        end

        NOSEL: begin
          if (AS_L) begin
            state         <= IDLE;
            CycleActive_H <= 1'b0;
          end else begin
            wd <= wd_next;
            if (wd == WD_LIMIT) begin
              state        <= BERR;
              BErr_L       <= 1'b0;
              BerrSticky_H <= 1'b1;
            end
          end
        end

        ACK, BERR: begin
          if (AS_L) begin
            state         <= IDLE;
            Dtack_L       <= 1'b1;
            BErr_L        <= 1'b1;
            CycleActive_H <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          Dtack_L       <= 1'b1;
          BErr_L        <= 1'b1;
          CycleActive_H <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench for bus_cycle_controller: a driver predicts each cycle's outcome
// from the region rules, a monitor pops and compares on every DTACK/BERR assertion.
module tb_bus_cycle_controller;

  localparam int TIMEOUT = 16;

  logic Clk, Reset_H, AS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, OffBoardMemory_H;
  logic DramSelect_H, CanBusSelect_H, GraphicsCS_L;
  logic DramDtack_L, CanBusDtack_L, GraphicsDtack_L, ClearBerr_H;
  logic Dtack_L, BErr_L, CycleActive_H, BerrSticky_H;

  bus_cycle_controller #(
    .ROM_WAIT(1), .RAM_WAIT(1), .IO_WAIT(3), .OFFBRD_WAIT(4),
    .TIMEOUT(TIMEOUT), .CNT_W(5)
  ) dut (
    .Clk(Clk), .Reset_H(Reset_H), .AS_L(AS_L),
    .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
    .IOSelect_H(IOSelect_H), .OffBoardMemory_H(OffBoardMemory_H),
    .DramSelect_H(DramSelect_H), .CanBusSelect_H(CanBusSelect_H),
    .GraphicsCS_L(GraphicsCS_L), .DramDtack_L(DramDtack_L),
    .CanBusDtack_L(CanBusDtack_L), .GraphicsDtack_L(GraphicsDtack_L),
    .ClearBerr_H(ClearBerr_H), .Dtack_L(Dtack_L), .BErr_L(BErr_L),
    .CycleActive_H(CycleActive_H), .BerrSticky_H(BerrSticky_H)
  );

  typedef struct {
    bit is_berr;
    int start;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   sticky_model = 1'b0;
  logic prev_dtack = 1'b1;
  logic prev_berr  = 1'b1;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Monitor: every fresh DTACK or BERR assertion must match the oldest prediction.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_H === 1'b0) begin
      if ((prev_dtack === 1'b1 && Dtack_L === 1'b0) || (prev_berr === 1'b1 && BErr_L === 1'b0)) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          check("kind_is_berr", {31'd0, !BErr_L}, {31'd0, e.is_berr});
          check("latency", cyc - e.start, e.lat);
          check("dtack_berr_exclusive", {31'd0, Dtack_L | BErr_L}, 1);
        end
      end
    end
    prev_dtack = Dtack_L;
    prev_berr  = BErr_L;
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Drives one edge's worth of inputs. Selects are garbage after the start edge;
  // device acks are noise except the latched source, which goes low once src_low.
  task automatic drive_inputs(input int src, input bit src_low, input bit as_l,
                              input bit clr, input bit berr_edge);
    {OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, OffBoardMemory_H,
     DramSelect_H, CanBusSelect_H, GraphicsCS_L} = 7'($urandom);
    DramDtack_L     = (src == 4) ? !src_low : 1'($urandom);
    CanBusDtack_L   = (src == 5) ? !src_low : 1'($urandom);
    GraphicsDtack_L = (src == 6) ? !src_low : 1'($urandom);
    AS_L        = as_l;
    ClearBerr_H = clr;
    if (berr_edge) sticky_model = 1'b1;
    else if (clr)  sticky_model = 1'b0;
  endtask

  function automatic int wait_of(input int region);
    case (region)
      0: return 1;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_dtack"}, {31'd0, Dtack_L}, 1);
    check({tag, "_berr"}, {31'd0, BErr_L}, 1);
    check({tag, "_active"}, {31'd0, CycleActive_H}, 0);
    check({tag, "_sticky"}, {31'd0, BerrSticky_H}, {31'd0, sticky_model});
  endtask

  // sel bit order: ROM, RAM, IO, OFFBRD, DRAM, CAN, GRAPHICS (bit 0 = highest priority).
  // d: edge index after E at which the selected device ack is first sampled low.
  // a: edge index after E at which AS_L is sampled high (0 = no abort).
  task automatic do_cycle(input logic [6:0] sel, input int d, input int a,
                          input bit force_clr, input bit quiet);
    int region = -1;
    int src, lat, last, hold;
    bit is_berr, abort, clr;
    for (int i = 0; i < 7; i++) if (region < 0 && sel[i]) region = i;
    src = (region >= 4) ? region : -1;
    if (region < 0)           begin is_berr = 1'b1; lat = TIMEOUT; end
    else if (region < 4)      begin is_berr = 1'b0; lat = wait_of(region) + 1; end
    else if (d <= TIMEOUT)    begin is_berr = 1'b0; lat = d; end
    else                      begin is_berr = 1'b1; lat = TIMEOUT; end
    abort = (a != 0) && (a <= lat);

    drive_inputs(src, 1'b0, 1'b0, quiet ? 1'b0 : ($urandom_range(0, 3) == 0), 1'b0);
    {GraphicsCS_L, CanBusSelect_H, DramSelect_H, OffBoardMemory_H,
     IOSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = {!sel[6], sel[5:0]};
    if (!abort) sb.push_back('{is_berr, cyc + 1, lat});
    tick();
    check("active_after_start", {31'd0, CycleActive_H}, 1);

    last = abort ? a : lat;
    for (int k = 1; k <= last; k++) begin
      clr = (force_clr && k == lat) ? 1'b1 : (!quiet && $urandom_range(0, 3) == 0);
      drive_inputs(src, k >= d, abort && k == a, clr, !abort && is_berr && k == lat);
      tick();
    end
    if (!abort) begin
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        drive_inputs(src, 1'b1, 1'b0, !quiet && $urandom_range(0, 3) == 0, 1'b0);
        tick();
      end
      drive_inputs(src, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_idle(abort ? "after_abort" : "after_cycle");
  endtask

  initial begin
    logic [6:0] sel;
    int d, a;

    Reset_H = 1'b1;
    drive_inputs(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("reset_dtack", {31'd0, Dtack_L}, 1);
    check("reset_berr", {31'd0, BErr_L}, 1);
    check("reset_active", {31'd0, CycleActive_H}, 0);
    check("reset_sticky", {31'd0, BerrSticky_H}, 0);
    Reset_H = 1'b0;
    sticky_model = 1'b0;
    tick();

    do_cycle(7'b0000001, 0, 0, 1'b0, 1'b0);   // ROM: DTACK at E+2
    do_cycle(7'b0000100, 0, 0, 1'b0, 1'b0);   // IO: DTACK at E+4
    do_cycle(7'b0010000, 7, 0, 1'b0, 1'b0);   // DRAM acks at 7, CAN noise ignored
    do_cycle(7'b0000000, 0, 0, 1'b0, 1'b1);   // unmapped: BERR at E+16
    check("sticky_held", {31'd0, BerrSticky_H}, 1);
    drive_inputs(-1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("sticky_cleared", {31'd0, BerrSticky_H}, 0);
    do_cycle(7'b0010000, TIMEOUT, 0, 1'b0, 1'b0);  // ack and timeout race: ack wins
    do_cycle(7'b0000000, 0, 0, 1'b1, 1'b1);        // set and clear together: set wins
    do_cycle(7'b0010001, 3, 0, 1'b0, 1'b0);        // ROM+DRAM: ROM timing
    do_cycle(7'b1000000, 5, 0, 1'b0, 1'b0);        // graphics, active-low select
    do_cycle(7'b0000001, 0, 2, 1'b0, 1'b0);        // abort on the ack edge

    // Reset during an external cycle with the sticky flag set.
    do_cycle(7'b0000000, 0, 0, 1'b0, 1'b1);
    drive_inputs(5, 1'b0, 1'b0, 1'b0, 1'b0);
    {GraphicsCS_L, CanBusSelect_H, DramSelect_H, OffBoardMemory_H,
     IOSelect_H, OnChipRamSelect_H, OnChipRomSelect_H} = 7'b1100000;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive_inputs(5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    Reset_H = 1'b1;
    tick();
    sticky_model = 1'b0;
    check_idle("reset_in_ext");
    Reset_H = 1'b0;
    drive_inputs(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) sel = 7'd0;
      else sel = 7'(1 << $urandom_range(0, 6)) | (($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0);
      d = $urandom_range(1, TIMEOUT + 4);
      a = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TIMEOUT + 2) : 0;
      if ($urandom_range(0, 2) == 0) begin
        drive_inputs(-1, 1'b0, 1'b1, $urandom_range(0, 3) == 0, 1'b0);
        tick();
      end
      do_cycle(sel, d, a, 1'b0, 1'b0);
    end

    repeat (2) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
